// File: rtl/hps_io_cmd_decoder_pkg.sv
// Shared definitions for the HPS IO command decoder: command codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package hps_io_cmd_decoder_pkg;

  localparam logic [15:0] UIO_BUT_SW     = 16'h0001;
  localparam logic [15:0] UIO_JOY0       = 16'h0002;
  localparam logic [15:0] UIO_JOY1       = 16'h0003;
  localparam logic [15:0] UIO_SET_STATUS = 16'h001E;
  localparam logic [15:0] UIO_GET_STATUS = 16'h0029;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/hps_io_cmd_decoder.sv
// HPS IO command decoder: turns io_enable-framed SPI words into buttons/joystick/status registers and gp_in readback.
// Latency: every register update lands on the sys_clk edge after the io_strobe cycle.
// Backpressure: none; each strobed word is consumed in its cycle, words past the saturated counter are dropped.
module hps_io_cmd_decoder
  import hps_io_cmd_decoder_pkg::*;
#(
  parameter int STATUS_WORDS = 8,
  parameter int WCNT_W       = 8
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic [31:0]                 gp_out,
  input  logic                        io_strobe,
  output logic [15:0]                 gp_in,
  output logic [15:0]                 cmd,
  output logic [15:0]                 buttons,
  output logic [31:0]                 joystick_0,
  output logic [31:0]                 joystick_1,
  output logic [16*STATUS_WORDS-1:0]  status,
  output logic                        status_update
);

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  logic                       io_en;
  logic [15:0]                word;
  logic                       unused_gp_out;
  state_t                     state;
  state_t                     state_nxt;
  logic                       cmd_stb;
  logic                       data_stb;
  logic [WCNT_W-1:0]          word_cnt;
  logic [15:0]                rd_word;
  logic [16*STATUS_WORDS-1:0] shadow;
  logic [16*STATUS_WORDS-1:0] shadow_mrg;

  assign io_en         = gp_out[20];
  assign word          = gp_out[15:0];
  assign unused_gp_out = ^{gp_out[31:21], gp_out[19:16]};

  // FSM state register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, and qualification of strobes as command or data words; io_en low wins over a strobe
  always_comb begin
    state_nxt = state;
    cmd_stb   = 1'b0;
    data_stb  = 1'b0;
    if (!io_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_CMD;
        ST_CMD: begin
          if (io_strobe) begin
            cmd_stb   = 1'b1;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: data_stb = io_strobe && (word_cnt != WCNT_MAX);
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status word addressed by the current word counter, used for get-status readback
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < STATUS_WORDS; i++) begin
      if (word_cnt == WCNT_W'(i)) rd_word = status[16*i +: 16];
    end
  end

  // Shadow with the incoming data word merged in at its index
  always_comb begin
    shadow_mrg = shadow;
    for (int i = 0; i < STATUS_WORDS; i++) begin
      if (word_cnt == WCNT_W'(i + 1)) shadow_mrg[16*i +: 16] = word;
    end
  end

  // Command/word-counter tracking, readback word and button/joystick decode
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cmd        <= '0;
      word_cnt   <= '0;
      gp_in      <= '0;
      buttons    <= '0;
      joystick_0 <= '0;
      joystick_1 <= '0;
    end else if (!io_en) begin
      cmd      <= '0;
      word_cnt <= '0;
      gp_in    <= '0;
    end else if (cmd_stb) begin
      cmd      <= word;
      word_cnt <= WCNT_W'(1);
      gp_in    <= (word == UIO_GET_STATUS) ? rd_word : '0;
    end else if (data_stb) begin
      word_cnt <= word_cnt + WCNT_W'(1);
      gp_in    <= (cmd == UIO_GET_STATUS) ? rd_word : '0;
      case (cmd)
        UIO_BUT_SW: if (word_cnt == WCNT_W'(1)) buttons <= word;
        UIO_JOY0: begin
          if (word_cnt == WCNT_W'(1))      joystick_0[15:0]  <= word;
          else if (word_cnt == WCNT_W'(2)) joystick_0[31:16] <= word;
        end
        UIO_JOY1: begin
          if (word_cnt == WCNT_W'(1))      joystick_1[15:0]  <= word;
          else if (word_cnt == WCNT_W'(2)) joystick_1[31:16] <= word;
        end
        default: ;
      endcase
    end
  end

  // Status shadow fill and commit; a partial frame leaves status alone and the shadow is reloaded next time
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      shadow        <= '0;
      status        <= '0;
      status_update <= 1'b0;
    end else begin
      status_update <= 1'b0;
      if (cmd_stb && (word == UIO_SET_STATUS)) begin
        shadow <= status;
      end else if (data_stb && (cmd == UIO_SET_STATUS)) begin
        shadow <= shadow_mrg;
        if (word_cnt == WCNT_W'(STATUS_WORDS)) begin
          status        <= shadow_mrg;
          status_update <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hps_io_cmd_decoder.sv
// Self-checking bench for hps_io_cmd_decoder: directed frames plus random frames against a word-level model.
// Latency: outputs checked on the falling edge after each strobed rising edge.
// Backpressure: none; the bench drives strobes freely.
module tb_hps_io_cmd_decoder;
  import hps_io_cmd_decoder_pkg::*;

  localparam int SWN = 8;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [31:0]   gp_out;
  logic          io_strobe;
  logic [15:0]   gp_in;
  logic [15:0]   cmd;
  logic [15:0]   buttons;
  logic [31:0]   joystick_0;
  logic [31:0]   joystick_1;
  logic [127:0]  status;
  logic          status_update;

  hps_io_cmd_decoder #(.STATUS_WORDS(SWN), .WCNT_W(8)) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .gp_out        (gp_out),
    .io_strobe     (io_strobe),
    .gp_in         (gp_in),
    .cmd           (cmd),
    .buttons       (buttons),
    .joystick_0    (joystick_0),
    .joystick_1    (joystick_1),
    .status        (status),
    .status_update (status_update)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0]  gp_in;
    logic [15:0]  cmd;
    logic [15:0]  buttons;
    logic [31:0]  joy0;
    logic [31:0]  joy1;
    logic [127:0] status;
    logic         upd;
  } snap_t;

  snap_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    pulses = 0;
  int    exp_pulses = 0;

  // Reference model: state of the frame at the word level
  logic        m_active;
  int          m_pos;
  logic [15:0] m_cmd;
  logic [15:0] m_gp;
  logic [15:0] m_buttons;
  logic [31:0] m_joy [2];
  logic [15:0] m_status [SWN];
  logic [15:0] m_shadow [SWN];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_status_vec();
    logic [127:0] r;
    for (int i = 0; i < SWN; i++) r[16*i +: 16] = m_status[i];
    return r;
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_pos     = 0;
    m_cmd     = '0;
    m_gp      = '0;
    m_buttons = '0;
    m_joy[0]  = '0;
    m_joy[1]  = '0;
    for (int i = 0; i < SWN; i++) begin
      m_status[i] = '0;
      m_shadow[i] = '0;
    end
  endtask

  task automatic model_drop();
    m_active = 1'b0;
    m_cmd    = '0;
    m_gp     = '0;
  endtask

  // Apply one strobed word to the model and queue the outputs expected one cycle later
  task automatic model_word(input logic [15:0] w);
    snap_t s;
    logic  upd;
    int    n;
    int    j;
    upd = 1'b0;
    if (gp_out[20] !== 1'b1) begin
      model_drop();
    end else if (!m_active) begin
      m_active = 1'b1;
      m_cmd    = w;
      m_pos    = 1;
      m_gp     = (w == UIO_GET_STATUS) ? m_status[0] : 16'h0;
      if (w == UIO_SET_STATUS) m_shadow = m_status;
    end else if (m_pos < 255) begin
      n = m_pos;
      m_pos++;
      m_gp = '0;
      case (m_cmd)
        UIO_BUT_SW: if (n == 1) m_buttons = w;
        UIO_JOY0, UIO_JOY1: begin
          j = (m_cmd == UIO_JOY1) ? 1 : 0;
          if (n == 1)      m_joy[j][15:0]  = w;
          else if (n == 2) m_joy[j][31:16] = w;
        end
        UIO_SET_STATUS: begin
          if (n <= SWN) begin
            m_shadow[n-1] = w;
            if (n == SWN) begin
              m_status = m_shadow;
              upd = 1'b1;
              exp_pulses++;
            end
          end
        end
        UIO_GET_STATUS: m_gp = (n < SWN) ? m_status[n] : 16'h0;
        default: ;
      endcase
    end
    s.gp_in   = m_gp;
    s.cmd     = m_cmd;
    s.buttons = m_buttons;
    s.joy0    = m_joy[0];
    s.joy1    = m_joy[1];
    s.status  = m_status_vec();
    s.upd     = upd;
    exp_q.push_back(s);
  endtask

  // Monitor: each strobed edge presents a result, compared on the following falling edge
  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge sys_clk);
      if (io_strobe === 1'b1 && reset === 1'b0) begin
        @(negedge sys_clk);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: DUT result with no expected entry");
        end else begin
          e = exp_q.pop_front();
          check("sb_gp_in",   gp_in,         e.gp_in);
          check("sb_cmd",     cmd,           e.cmd);
          check("sb_buttons", buttons,       e.buttons);
          check("sb_joy0",    joystick_0,    e.joy0);
          check("sb_joy1",    joystick_1,    e.joy1);
          check("sb_status",  status,        e.status);
          check("sb_update",  status_update, e.upd);
        end
      end
    end
  end

  always @(negedge sys_clk) if (status_update === 1'b1) pulses++;

  // Tasks start and end on a falling edge
  task automatic send_word(input logic [15:0] w, input int gap);
    gp_out[15:0] = w;
    io_strobe    = 1'b1;
    model_word(w);
    @(negedge sys_clk);
    io_strobe = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic set_en(input logic en);
    gp_out[20] = en;
    if (!en) model_drop();
    @(negedge sys_clk);
    if (!en) begin
      check("drop_cmd",   cmd,   16'h0);
      check("drop_gp_in", gp_in, 16'h0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gp_in"},   gp_in,         0);
    check({tag, "_cmd"},     cmd,           0);
    check({tag, "_buttons"}, buttons,       0);
    check({tag, "_joy0"},    joystick_0,    0);
    check({tag, "_joy1"},    joystick_1,    0);
    check({tag, "_status"},  status,        0);
    check({tag, "_update"},  status_update, 0);
  endtask

  initial begin : stim
    int p0;
    int len;
    int pick;
    logic [15:0] cw;
    reset     = 1'b1;
    gp_out    = '0;
    io_strobe = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge sys_clk);

    // Buttons
    set_en(1'b1);
    send_word(16'h0001, 0);
    send_word(16'hA55A, 1);
    check("buttons_dir", buttons, 16'hA55A);
    check("joy0_after_buttons", joystick_0, 0);
    set_en(1'b0);

    // Joystick 0
    set_en(1'b1);
    send_word(16'h0002, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 1);
    set_en(1'b0);
    check("joy0_dir", joystick_0, 32'hABCD1234);
    check("joy1_dir", joystick_1, 0);

    // Full set-status frame
    p0 = pulses;
    set_en(1'b1);
    send_word(16'h001E, 1);
    for (int i = 1; i <= SWN; i++) send_word(16'(i), 0);
    set_en(1'b0);
    check("status_dir", status, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("status_pulses", pulses - p0, 1);

    // Partial set-status frame
    p0 = pulses;
    set_en(1'b1);
    send_word(16'h001E, 0);
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 0);
    set_en(1'b0);
    check("status_partial", status, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("partial_pulses", pulses - p0, 0);

    // Get-status readback, nine data words
    set_en(1'b1);
    send_word(16'h0029, 0);
    check("get_first", gp_in, 16'h0001);
    for (int i = 0; i < 9; i++) send_word(16'($urandom), 0);
    check("get_tail", gp_in, 16'h0000);
    set_en(1'b0);

    // Strobe on io_en fall, then strobe with io_en low
    set_en(1'b1);
    send_word(16'h0001, 0);
    gp_out[20] = 1'b0;
    send_word(16'h5555, 0);
    send_word(16'h7777, 1);
    check("buttons_ignored", buttons, 16'hA55A);
    set_en(1'b0);

    // Long joystick frame: counter must saturate, never wrap back to index 1
    set_en(1'b1);
    send_word(16'h0002, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    for (int i = 0; i < 258; i++) send_word(16'($urandom), 0);
    set_en(1'b0);
    check("joy0_saturate", joystick_0, 32'h2222_1111);

    // Reset in the middle of a set-status frame
    set_en(1'b1);
    send_word(16'h001E, 0);
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 0);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    model_reset();
    gp_out = '0;
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);

    // Random frames
    for (int f = 0; f < 60; f++) begin
      len  = int'($urandom_range(0, 11));
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: cw = UIO_BUT_SW;
        1: cw = UIO_JOY0;
        2: cw = UIO_JOY1;
        3: cw = UIO_SET_STATUS;
        4: cw = UIO_GET_STATUS;
        default: cw = 16'h0100 | 16'($urandom_range(0, 255));
      endcase
      set_en(1'b1);
      send_word(cw, int'($urandom_range(0, 2)));
      for (int i = 0; i < len; i++) send_word(16'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        gp_out[20] = 1'b0;
        send_word(16'($urandom), 0);
      end
      set_en(1'b0);
      if ($urandom_range(0, 3) == 0) send_word(16'($urandom), 0);
    end

    begin : drain
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge sys_clk);
        budget--;
      end
      check("queue_drained", 128'(exp_q.size()), 0);
    end
    check("pulse_total", 128'(pulses), 128'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
